// File: rtl/synth_pkg.sv
// Shared definitions for the synth voice blocks.
// Holds the envelope state encoding and the common level/sample widths.
package synth_pkg;

   localparam int LEVEL_W  = 8;
   localparam int SAMPLE_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      ATTACK,
      DECAY,
      SUSTAIN,
      RELEASE
   } env_state_t;

endpackage

// File: rtl/env_tick_gen.sv
// Envelope tick prescaler.
// Ports:
//   clk   - single clock
//   reset - synchronous active-high reset, clears the counter
//   tick  - one-cycle pulse every TICK_DIV clk cycles
// The counter runs 0..TICK_DIV-1 and tick is high while it sits on the last value.
module env_tick_gen #(
   parameter int unsigned TICK_DIV = 156250
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] count;

   assign tick = (count == LAST);

   // Free-running divider; wraps to zero on the same edge that ends the tick cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/note_envelope.sv
// ADSR-style envelope applied to an unsigned note sample.
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   gate          - key held (1) / released (0)
//   sample_in     - unsigned note sample, qualified by sample_valid
//   sample_out    - sample scaled by the current level, qualified by out_valid
//   level         - current envelope level
//   active        - high whenever the envelope is not IDLE
module note_envelope
   import synth_pkg::*;
#(
   parameter int unsigned TICK_DIV      = 156250,
   parameter int unsigned ATTACK_STEP   = 8,
   parameter int unsigned DECAY_STEP    = 2,
   parameter int unsigned SUSTAIN_LEVEL = 192,
   parameter int unsigned RELEASE_STEP  = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                gate,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                sample_valid,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic                out_valid,
   output logic [LEVEL_W-1:0]  level,
   output logic                active
);

   localparam logic [8:0] ATK9 = 9'(ATTACK_STEP);
   localparam logic [8:0] DEC9 = 9'(DECAY_STEP);
   localparam logic [8:0] SUS9 = 9'(SUSTAIN_LEVEL);
   localparam logic [7:0] SUS8 = 8'(SUSTAIN_LEVEL);
   localparam logic [7:0] DEC8 = 8'(DECAY_STEP);
   localparam logic signed [8:0] REL9 = 9'(RELEASE_STEP);

   env_state_t        state, next_state;
   logic [7:0]        next_level;
   logic              gate_d;
   logic              rise;
   logic              tick;
   logic [8:0]        atk_sum;
   logic signed [8:0] rel_diff;
   logic [15:0]       product;

   env_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign rise     = gate & ~gate_d;
   assign active   = (state != IDLE);
   assign atk_sum  = {1'b0, level} + ATK9;
   assign rel_diff = $signed({1'b0, level}) - REL9;
   // level+1 reaches 256 at full scale, so the product still fits in 16 bits.
   assign product  = 16'(sample_in) * (16'(level) + 16'd1);

   // State, level and gate history registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         level  <= '0;
         gate_d <= 1'b0;
      end else begin
         state  <= next_state;
         level  <= next_level;
         gate_d <= gate;
      end
   end

   // Next-state logic; gate events take precedence over a coincident tick.
   always_comb begin
      next_state = state;
      next_level = level;
      if (rise) begin
         next_state = ATTACK;
      end else begin
         case (state)
            IDLE: begin
               next_level = '0;
            end
            ATTACK: begin
               if (!gate) begin
                  next_state = RELEASE;
               end else if (tick) begin
                  if (atk_sum >= 9'd255) begin
                     next_level = 8'd255;
                     next_state = DECAY;
                  end else begin
                     next_level = atk_sum[7:0];
                  end
               end
            end
            DECAY: begin
               if (!gate) begin
                  next_state = RELEASE;
               end else if (tick) begin
                  // Clamp when the step would land on or below the sustain level.
                  if ({1'b0, level} <= SUS9 + DEC9) begin
                     next_level = SUS8;
                     next_state = SUSTAIN;
                  end else begin
                     next_level = level - DEC8;
                  end
               end
            end
            SUSTAIN: begin
               if (!gate) begin
                  next_state = RELEASE;
               end
            end
            RELEASE: begin
               if (tick) begin
                  if (rel_diff <= 9'sd0) begin
                     next_level = '0;
                     next_state = IDLE;
                  end else begin
                     next_level = rel_diff[7:0];
                  end
               end
            end
            default: begin
               next_state = IDLE;
               next_level = '0;
            end
         endcase
      end
   end

   // Output sample register; scaling uses the level from before this edge's update.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_out <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= sample_valid;
         if (sample_valid) begin
            sample_out <= (level == '0) ? '0 : 8'(product >> 8);
         end
      end
   end

endmodule

// File: tb/tb_note_envelope.sv
// Directed bench for note_envelope with a small scaling model and a scoreboard queue.
module tb_note_envelope;
   import synth_pkg::*;

   localparam int unsigned TD = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       gate;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic [7:0] sample_out;
   logic       out_valid;
   logic [7:0] level;
   logic       active;

   int         total = 0;
   int         bad   = 0;
   int         cyc;
   logic [7:0] expq[$];

   note_envelope #(
      .TICK_DIV      (TD),
      .ATTACK_STEP   (64),
      .DECAY_STEP    (32),
      .SUSTAIN_LEVEL (192),
      .RELEASE_STEP  (64)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .gate         (gate),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_out   (sample_out),
      .out_valid    (out_valid),
      .level        (level),
      .active       (active)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] modelScale(input logic [7:0] s, input logic [7:0] l);
      int unsigned p;
      if (l == 8'd0) return 8'd0;
      p = int'(s) * (int'(l) + 1);
      return 8'(p / 256);
   endfunction

   // Drives one valid sample for one cycle and checks the registered result.
   task automatic applyStimulus(input string tag, input logic [7:0] s, input logic [7:0] lvl);
      logic [7:0] e;
      sample_in    = s;
      sample_valid = 1'b1;
      expq.push_back(modelScale(s, lvl));
      step();
      checkOutput({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
      if (out_valid === 1'b1 && expq.size() > 0) begin
         e = expq.pop_front();
         checkOutput(tag, sample_out, e);
      end
   endtask

   task automatic sampleIdle(input logic [7:0] held);
      sample_valid = 1'b0;
      step();
      checkOutput("idle_out_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("idle_sample_held", sample_out, held);
   endtask

   task automatic waitLevel(input string tag, input logic [7:0] exp, output int cycles);
      logic [7:0] old;
      old = level;
      cycles = 0;
      while (level === old && cycles < 4 * TD) begin
         step();
         cycles++;
      end
      if (level === old) begin
         total++;
         bad++;
         $error("[TB] FAIL %s_timeout: observed=%0d expected=%0d", tag, level, exp);
      end else begin
         checkOutput(tag, level, exp);
      end
   endtask

   task automatic checkState(input string tag, input env_state_t exp);
      checkOutput(tag, 8'(dut.state), 8'(exp));
   endtask

   initial begin
      reset        = 1'b1;
      gate         = 1'b0;
      sample_in    = 8'd255;
      sample_valid = 1'b1;
      step();
      step();
      checkOutput("rst_level", level, 8'd0);
      checkOutput("rst_active", {7'd0, active}, 8'd0);
      checkOutput("rst_out_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("rst_sample_out", sample_out, 8'd0);
      checkState("rst_state", IDLE);

      reset        = 1'b0;
      sample_valid = 1'b0;
      step();
      applyStimulus("scale_level0", 8'd255, 8'd0);
      sampleIdle(8'd0);

      gate = 1'b1;
      step();
      checkState("attack_entry", ATTACK);
      checkOutput("attack_active", {7'd0, active}, 8'd1);
      checkOutput("attack_level0", level, 8'd0);
      waitLevel("atk1", 8'd64, cyc);
      waitLevel("atk2", 8'd128, cyc);
      checkOutput("tick_period2", 8'(cyc), 8'(TD));
      waitLevel("atk3", 8'd192, cyc);
      checkOutput("tick_period3", 8'(cyc), 8'(TD));
      waitLevel("atk4", 8'd255, cyc);
      checkOutput("tick_period4", 8'(cyc), 8'(TD));
      checkState("decay_entry", DECAY);
      applyStimulus("scale_level255", 8'd255, 8'd255);
      sampleIdle(8'd255);
      waitLevel("dec1", 8'd223, cyc);
      waitLevel("dec2", 8'd192, cyc);
      checkState("sustain_entry", SUSTAIN);

      applyStimulus("scale_200", 8'd200, 8'd192);
      applyStimulus("scale_b2b_a", 8'd100, 8'd192);
      applyStimulus("scale_b2b_b", 8'd50, 8'd192);
      sampleIdle(8'd37);
      repeat (10) step();
      checkOutput("sustain_hold", level, 8'd192);
      checkState("sustain_stay", SUSTAIN);

      gate = 1'b0;
      step();
      checkState("release_entry", RELEASE);
      checkOutput("release_level", level, 8'd192);
      waitLevel("rel1", 8'd128, cyc);
      waitLevel("rel2", 8'd64, cyc);
      waitLevel("rel3", 8'd0, cyc);
      checkState("idle_entry", IDLE);
      checkOutput("idle_active", {7'd0, active}, 8'd0);
      repeat (8) step();
      checkOutput("idle_hold", level, 8'd0);

      gate = 1'b1;
      step();
      checkState("attack2_entry", ATTACK);
      waitLevel("atk2_1", 8'd64, cyc);
      waitLevel("atk2_2", 8'd128, cyc);
      waitLevel("atk2_3", 8'd192, cyc);
      waitLevel("atk2_4", 8'd255, cyc);
      waitLevel("dec2_1", 8'd223, cyc);
      waitLevel("dec2_2", 8'd192, cyc);
      gate = 1'b0;
      step();
      waitLevel("rel2_1", 8'd128, cyc);
      checkState("release2", RELEASE);
      gate = 1'b1;
      step();
      checkState("retrigger_state", ATTACK);
      checkOutput("retrigger_level", level, 8'd128);
      waitLevel("retrigger_tick", 8'd192, cyc);
      checkState("retrigger_still_attack", ATTACK);

      reset        = 1'b1;
      sample_in    = 8'd255;
      sample_valid = 1'b1;
      step();
      checkOutput("midrst_level", level, 8'd0);
      checkOutput("midrst_active", {7'd0, active}, 8'd0);
      checkOutput("midrst_out_valid", {7'd0, out_valid}, 8'd0);
      checkOutput("midrst_sample_out", sample_out, 8'd0);
      checkState("midrst_state", IDLE);
      reset        = 1'b0;
      sample_valid = 1'b0;
      step();
      checkState("post_rst_attack", ATTACK);
      checkOutput("post_rst_active", {7'd0, active}, 8'd1);
      checkOutput("post_rst_level", level, 8'd0);
      waitLevel("post_rst_atk1", 8'd64, cyc);

      checkOutput("queue_empty", 8'(expq.size()), 8'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
